// File: rtl/apb_master_bridge_pkg.sv
// rtl/apb_master_bridge_pkg.sv - shared types and constants for the APB master bridge
//  Provides the bridge FSM state encoding, the per-slave address span, and a
//  helper that sizes slave-index fields (never narrower than one bit).
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } apb_state_e;

    localparam logic [31:0] APB_SLAVE_SPAN  = 32'h1000;
    localparam int          APB_SPAN_SHIFT  = 12;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - APB3 bus bundle between the bridge and its slaves
//  Signals: PADDR/PWRITE/PWDATA/PENABLE/PSEL driven by the master,
//  PRDATA (slave i at [32*i +: 32]) and PREADY (one bit per slave) driven by slaves.
//  Modports: master (bridge side), slave (peripheral side).
interface apb_master_bridge_if #(
    parameter int NUM_SLAVES = 4
);
    logic [31:0]               PADDR;
    logic                      PWRITE;
    logic [31:0]               PWDATA;
    logic                      PENABLE;
    logic [NUM_SLAVES-1:0]     PSEL;
    logic [NUM_SLAVES*32-1:0]  PRDATA;
    logic [NUM_SLAVES-1:0]     PREADY;

    modport master (
        output PADDR, PWRITE, PWDATA, PENABLE, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PWDATA, PENABLE, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_master_bridge_decoder.sv
// rtl/apb_master_bridge_decoder.sv - combinational peripheral-window address decoder
//  Ports:
//   addr        in   32          byte address from the core
//   hit         out  1           address falls inside the NUM_SLAVES * 4 KiB window
//   idx         out  IDX_W       slave index (valid only when hit=1)
//   psel_onehot out  NUM_SLAVES  one-hot select, all zero on a miss
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] ADDR_BASE  = 32'h1000_0000,
    parameter int          IDX_W      = 2
) (
    input  logic [31:0]           addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx,
    output logic [NUM_SLAVES-1:0] psel_onehot
);

    localparam logic [31:0] WINDOW = 32'(NUM_SLAVES) * APB_SLAVE_SPAN;

    logic [31:0] offset;

    // Unsigned subtraction wraps addresses below the base to large values,
    // so a single compare covers both ends of the window.
    always_comb begin
        offset      = addr - ADDR_BASE;
        hit         = (offset < WINDOW);
        idx         = IDX_W'(offset >> APB_SPAN_SHIFT);
        psel_onehot = hit ? (NUM_SLAVES'(1) << idx) : '0;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - core data-bus to APB3 master bridge with address decode and timeout
//  Ports:
//   clk, reset        clock (rising edge) and asynchronous active-low reset
//   transfer          core request strobe, samples busWe/busAddr/busWData in IDLE
//   busWe/busAddr/busWData   core request fields
//   busRData          read data, non-zero only while ready=1
//   ready             one-cycle completion pulse
//   error             qualifies ready: unmapped address or slave timeout
//   apb               APB3 master bundle (PADDR/PWRITE/PWDATA/PENABLE/PSEL/PRDATA/PREADY)
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES  = 4,
    parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                transfer,
    input  logic                busWe,
    input  logic [31:0]         busAddr,
    input  logic [31:0]         busWData,
    output logic [31:0]         busRData,
    output logic                ready,
    output logic                error,
    apb_master_bridge_if.master apb
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    // The counter value seen in the last permitted ACCESS cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    apb_state_e            state_q, state_d;
    logic [31:0]           addr_q,  addr_d;
    logic                  we_q,    we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [NUM_SLAVES-1:0] psel_q,  psel_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [NUM_SLAVES-1:0] dec_psel;

    logic                  pready_sel;
    logic [31:0]           prdata_sel;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_BASE  (ADDR_BASE),
        .IDX_W      (IDX_W)
    ) u_decoder (
        .addr        (busAddr),
        .hit         (dec_hit),
        .idx         (dec_idx),
        .psel_onehot (dec_psel)
    );

    // Only the latched slave's PREADY/PRDATA matter; others are masked out.
    assign pready_sel = |(apb.PREADY & psel_q);
    assign prdata_sel = apb.PRDATA[{idx_q, 5'b0} +: 32];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        psel_d  = psel_q;
        cnt_d   = cnt_q;
        rdata_d = '0;
        ready_d = 1'b0;
        error_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    addr_d  = busAddr;
                    we_d    = busWe;
                    wdata_d = busWData;
                    idx_d   = dec_idx;
                    psel_d  = dec_psel;
                    state_d = dec_hit ? SETUP : ERR;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (pready_sel) begin
                    ready_d = 1'b1;
                    rdata_d = we_q ? 32'h0 : prdata_sel;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            ERR: begin
                ready_d = 1'b1;
                error_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            psel_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            psel_q  <= psel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // PSEL/PENABLE decode straight from the state register so a reset
    // drops them in the same instant rather than at the next edge.
    assign apb.PSEL    = (state_q == SETUP || state_q == ACCESS) ? psel_q : '0;
    assign apb.PENABLE = (state_q == ACCESS);
    assign apb.PADDR   = addr_q;
    assign apb.PWRITE  = we_q;
    assign apb.PWDATA  = wdata_q;

    assign busRData = rdata_q;
    assign ready    = ready_q;
    assign error    = error_q;

endmodule
